// File: rtl/seq_detect_shifter.sv
// Serial pattern detector: after a PATTERN match it shifts in SHIFT_LEN payload bits,
// counts the payload value down to zero, then holds done until acknowledged.
module seq_detect_shifter #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   SHIFT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data,
  input  logic                 ack,
  output logic                 start_shifting,
  output logic                 shift_ena,
  output logic [SHIFT_LEN-1:0] captured,
  output logic                 counting,
  output logic [SHIFT_LEN-1:0] count,
  output logic                 done
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam int SCNT_W = $clog2(SHIFT_LEN + 1);

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(PATTERN_W - 1);
  localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(SHIFT_LEN - 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state;
  logic [PATTERN_W-1:0] history;
  logic [FILL_W-1:0]    fill;
  logic [SCNT_W-1:0]    shift_cnt;
  logic [PATTERN_W-1:0] hist_nx;
  logic [SHIFT_LEN-1:0] cap_nx;
  logic                 match;

  generate
    if (PATTERN_W == 1) begin : g_hist1
      assign hist_nx = data;
    end else begin : g_histn
      assign hist_nx = {history[PATTERN_W-2:0], data};
    end
    if (SHIFT_LEN == 1) begin : g_cap1
      assign cap_nx = data;
    end else begin : g_capn
      assign cap_nx = {captured[SHIFT_LEN-2:0], data};
    end
  endgenerate

  // The fill check guarantees a match only ever uses bits received since the last clear.
  assign match = (state == S_SEARCH) && (fill >= FILL_LAST) && (hist_nx == PATTERN);

  assign shift_ena = (state == S_SHIFT);
  assign counting  = (state == S_COUNT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_SEARCH;
      history        <= '0;
      fill           <= '0;
      shift_cnt      <= '0;
      captured       <= '0;
      count          <= '0;
      start_shifting <= 1'b0;
    end else begin
      start_shifting <= 1'b0;
      case (state)
        S_SEARCH: begin
          history <= hist_nx;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
          if (match) begin
            state          <= S_SHIFT;
            start_shifting <= 1'b1;
            shift_cnt      <= '0;
          end
        end
        S_SHIFT: begin
          captured  <= cap_nx;
          shift_cnt <= shift_cnt + 1'b1;
          if (shift_cnt == SHIFT_LAST) begin
            state <= S_COUNT;
            count <= cap_nx;
          end
        end
        S_COUNT: begin
          if (count == '0) state <= S_DONE;
          else             count <= count - 1'b1;
        end
        default: begin
          if (ack) begin
            state   <= S_SEARCH;
            history <= '0;
            fill    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_shifter.sv
// Bench for seq_detect_shifter: vector table, directed corner sequences and
// randomized traffic against a queue-based behavioural model.
module tb_seq_detect_shifter;

  localparam int             PW  = 4;
  localparam logic [PW-1:0]  PAT = 4'b1101;
  localparam int             SL  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data = 1'b0;
  logic          ack = 1'b0;
  logic          start_shifting, shift_ena, counting, done;
  logic [SL-1:0] captured, count;

  seq_detect_shifter #(.PATTERN_W(PW), .PATTERN(PAT), .SHIFT_LEN(SL)) dut (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
    .start_shifting(start_shifting), .shift_ena(shift_ena), .captured(captured),
    .counting(counting), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 search, 1 payload, 2 countdown, 3 waiting for ack
  int phase = 0;
  bit seen[$];
  int m_cap = 0;
  int m_cnt = 0;
  int m_got = 0;
  bit m_start = 0;

  function automatic bit tail_is_pattern();
    logic [PW-1:0] p;
    p = PAT;
    if (seen.size() < PW) return 1'b0;
    for (int i = 0; i < PW; i++)
      if (seen[seen.size() - PW + i] != p[PW-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit d, input bit a);
    if (r) begin
      phase = 0; seen.delete(); m_cap = 0; m_cnt = 0; m_start = 0; m_got = 0;
    end else begin
      m_start = 0;
      case (phase)
        0: begin
          seen.push_back(d);
          if (seen.size() > PW) void'(seen.pop_front());
          if (tail_is_pattern()) begin
            phase = 1; m_start = 1; m_got = 0;
          end
        end
        1: begin
          m_cap = ((m_cap * 2) + int'(d)) % (1 << SL);
          m_got++;
          if (m_got == SL) begin
            phase = 2; m_cnt = m_cap;
          end
        end
        2: begin
          if (m_cnt == 0) phase = 3;
          else m_cnt--;
        end
        default: if (a) begin
          phase = 0; seen.delete();
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("start_shifting", 32'(start_shifting), 32'(m_start));
    chk("shift_ena", 32'(shift_ena), 32'(phase == 1));
    chk("counting", 32'(counting), 32'(phase == 2));
    chk("done", 32'(done), 32'(phase == 3));
    chk("captured", 32'(captured), 32'(m_cap));
    chk("count", 32'(count), 32'(m_cnt));
  endtask

  task automatic step(input bit r, input bit d, input bit a);
    reset = r; data = d; ack = a;
    @(posedge clk);
    model_edge(r, d, a);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r, d, a;
    bit st, ena, ce, dn;
    logic [SL-1:0] cap, cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, d, a, st, ena, ce, dn, input logic [SL-1:0] cap, cnt);
    vec_t v;
    v.r = r; v.d = d; v.a = a; v.st = st; v.ena = ena; v.ce = ce; v.dn = dn;
    v.cap = cap; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    //   r d a  st en ce dn  cap  cnt
    add(1,0,0, 0,0,0,0, 4'h0,4'h0);
    add(0,1,0, 0,0,0,0, 4'h0,4'h0);
    add(0,1,0, 0,0,0,0, 4'h0,4'h0);
    add(0,0,0, 0,0,0,0, 4'h0,4'h0);
    add(0,1,0, 1,1,0,0, 4'h0,4'h0);
    add(0,0,0, 0,1,0,0, 4'h0,4'h0);
    add(0,1,0, 0,1,0,0, 4'h1,4'h0);
    add(0,0,0, 0,1,0,0, 4'h2,4'h0);
    add(0,1,0, 0,0,1,0, 4'h5,4'h5);
    add(0,0,0, 0,0,1,0, 4'h5,4'h4);
    add(0,0,1, 0,0,1,0, 4'h5,4'h3);
    add(0,0,0, 0,0,1,0, 4'h5,4'h2);
    add(0,1,0, 0,0,1,0, 4'h5,4'h1);
    add(0,0,0, 0,0,1,0, 4'h5,4'h0);
    add(0,0,1, 0,0,0,1, 4'h5,4'h0);
    add(0,0,0, 0,0,0,1, 4'h5,4'h0);
    add(0,0,1, 0,0,0,0, 4'h5,4'h0);
    add(0,1,0, 0,0,0,0, 4'h5,4'h0);
    add(0,1,0, 0,0,0,0, 4'h5,4'h0);
    add(0,0,0, 0,0,0,0, 4'h5,4'h0);
    add(0,1,0, 1,1,0,0, 4'h5,4'h0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d.start", i), 32'(start_shifting), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.ena", i), 32'(shift_ena), 32'(tbl[i].ena));
      chk($sformatf("tbl%0d.counting", i), 32'(counting), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d.captured", i), 32'(captured), 32'(tbl[i].cap));
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
    end

    // Overlapping match: 1,1,1,0,1 matches only on the fifth bit
    step(1, 0, 0);
    step(0, 1, 0); chk("ovl.b1", 32'(start_shifting), 0);
    step(0, 1, 0); chk("ovl.b2", 32'(start_shifting), 0);
    step(0, 1, 0); chk("ovl.b3", 32'(start_shifting), 0);
    step(0, 0, 0); chk("ovl.b4", 32'(start_shifting), 0);
    step(0, 1, 0); chk("ovl.b5", 32'(start_shifting), 1);

    // Zero payload: one COUNT cycle, then DONE held until ack
    for (int i = 0; i < SL; i++) step(0, 0, 0);
    chk("zero.counting", 32'(counting), 1);
    chk("zero.count", 32'(count), 0);
    step(0, 1, 0);
    chk("zero.done", 32'(done), 1);
    chk("zero.counting_off", 32'(counting), 0);
    for (int i = 0; i < 10; i++) step(0, i[0], 0);
    chk("zero.done_held", 32'(done), 1);
    step(0, 0, 1);
    chk("zero.ack_exit", 32'(done), 0);

    // Reset during the second SHIFT cycle aborts the frame
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
    chk("rst.match", 32'(start_shifting), 1);
    step(0, 1, 0);
    step(1, 1, 1);
    chk("rst.outputs", {start_shifting, shift_ena, counting, done, captured, count}, 0);
    begin
      bit s[7] = '{1, 0, 1, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        step(0, s[i], 0);
        chk($sformatf("rst.redetect%0d", i), 32'(start_shifting), 32'(i == 6));
      end
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, d, a;
      r = ($urandom_range(0, 79) == 0);
      d = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 3) == 0);
      step(r, d, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_shifter.md
SEQ_DETECT_SHIFTER -- requirements
Module: seq_detect_shifter

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4, giving the detected pattern length in bits (>=1).
REQ-002 SHALL have parameter PATTERN, default 4'b1101, giving the pattern; the MSB is the first bit received.
REQ-003 SHALL have parameter SHIFT_LEN, default 4, giving the number of payload bits captured after detection (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port data, input, 1 bit: the serial input, sampled on each rising clk edge.
REQ-007 SHALL have port ack, input, 1 bit: the acknowledge for done; it is honoured only in DONE.
REQ-008 SHALL have port start_shifting, output, 1 bit: a registered one-cycle pulse marking the first SHIFT cycle.
REQ-009 SHALL have port shift_ena, output, 1 bit: high for exactly SHIFT_LEN consecutive cycles while in SHIFT.
REQ-010 SHALL have port captured, output, SHIFT_LEN bits: the payload, MSB-first, held stable outside SHIFT.
REQ-011 SHALL have port counting, output, 1 bit: high while in COUNT.
REQ-012 SHALL have port count, output, SHIFT_LEN bits: the remaining count value.
REQ-013 SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-014 SHALL implement the states SEARCH, SHIFT, COUNT and DONE, encoded one-hot or binary at implementer's choice; the state SHALL NOT be visible on the ports.
REQ-015 In SEARCH, SHALL shift data into a PATTERN_W-bit history register (new bit enters at the LSB) and count received bits, saturating at PATTERN_W.
REQ-016 A match SHALL occur on the edge where the fill count including the current bit reaches PATTERN_W and {history[PATTERN_W-2:0], data} == PATTERN; the pattern is never matched on stale or cleared history, including when PATTERN is all zeros.
REQ-017 Matching within SEARCH SHALL be overlapping: for 1101, the stream 1,1,1,0,1 matches on the 5th bit.
REQ-018 On a match, SHALL enter SHIFT on the next cycle, with start_shifting=1 for that first SHIFT cycle only.
REQ-019 In SHIFT, SHALL assert shift_ena and, on each edge, set captured <= {captured[SHIFT_LEN-2:0], data}; the bit sampled on the match edge is not payload.
REQ-020 After SHIFT_LEN SHIFT edges, SHALL enter COUNT with count loaded with the final captured value; SHIFT SHALL last exactly SHIFT_LEN cycles.
REQ-021 In COUNT, SHALL assert counting; on each edge with count!=0, count SHALL decrement by 1; on the edge with count==0, SHALL move to DONE, so COUNT lasts captured+1 cycles, with captured=0 giving 1 cycle.
REQ-022 count SHALL never wrap below zero; outside COUNT it holds its last value, which is 0 after COUNT.
REQ-023 In DONE, done SHALL be 1 until an edge with ack=1; that edge SHALL return to SEARCH with history and fill count cleared.
REQ-024 ack SHALL be ignored in SEARCH, SHIFT and COUNT; ack high on the same edge that enters DONE SHALL NOT exit DONE.
REQ-025 data SHALL be ignored outside SEARCH and SHIFT, so no pattern detection occurs in COUNT or DONE.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from data or ack.

Reset
REQ-027 reset=1 at an edge SHALL force, from any state: state=SEARCH, history=0, fill count=0, captured=0, count=0, and start_shifting, shift_ena, counting and done all 0.
REQ-028 reset SHALL take priority over every other input, including a simultaneous match or ack.
REQ-029 Reset mid-operation SHALL abort the frame; detection SHALL restart requiring a full PATTERN_W fresh bits.

Verification (defaults: PATTERN=1101, SHIFT_LEN=4)
REQ-030 Reset, then data 1,1,0,1 -> start_shifting pulses 1 cycle after the 4th bit, and shift_ena is high for exactly 4 cycles.
REQ-031 Data 1,1,1,0,1 after reset -> exactly one match, on the 5th bit, with no earlier start_shifting.
REQ-032 Match, then payload 0,1,0,1 -> captured=4'b0101, counting high 6 cycles with count 5,4,3,2,1,0, then done=1.
REQ-033 Payload 0,0,0,0 -> counting for 1 cycle, then done on the following cycle.
REQ-034 ack=1 during COUNT -> ignored; done then holds for 10 cycles with ack=0, ack=1 for one edge -> done=0, and a fresh 1101 is required for the next detection.
REQ-035 reset=1 during the 2nd SHIFT cycle -> all outputs 0 next cycle, and the stream 1,0,1 (partial) then 1,1,0,1 detects only on the final 1.
